// File: rtl/csr_file_if.sv
`default_nettype none
// ============================================================================
// csr_file_if : decode / writeback / fetch side of the machine-mode CSR file
// Rev 1.0
// ============================================================================
interface csr_file_if #(
  parameter int XLEN = 64
);
  logic [11:0]     RD_ADDR;
  logic [XLEN-1:0] RD_DATA;
  logic            RD_ILLEGAL;
  logic            WB_ST_CSR;
  logic [11:0]     WB_CSR_ADDR;
  logic [XLEN-1:0] WB_CSR_DATA;
  logic            WB_RETIRE;
  logic            WB_CS;
  logic [XLEN-1:0] WB_CAUSE;
  logic [XLEN-1:0] WB_TRAP_PC;
  logic [XLEN-1:0] WB_TVAL;
  logic            WB_MRET;
  logic            TIMER;
  logic            EXTERNAL;
  logic            REDIRECT;
  logic [XLEN-1:0] REDIRECT_PC;
  logic            PRIVILEGE;
  logic            INT_REQ;

  modport master (
    output RD_ADDR, WB_ST_CSR, WB_CSR_ADDR, WB_CSR_DATA, WB_RETIRE, WB_CS,
           WB_CAUSE, WB_TRAP_PC, WB_TVAL, WB_MRET, TIMER, EXTERNAL,
    input  RD_DATA, RD_ILLEGAL, REDIRECT, REDIRECT_PC, PRIVILEGE, INT_REQ
  );

  modport slave (
    input  RD_ADDR, WB_ST_CSR, WB_CSR_ADDR, WB_CSR_DATA, WB_RETIRE, WB_CS,
           WB_CAUSE, WB_TRAP_PC, WB_TVAL, WB_MRET, TIMER, EXTERNAL,
    output RD_DATA, RD_ILLEGAL, REDIRECT, REDIRECT_PC, PRIVILEGE, INT_REQ
  );
endinterface
`default_nettype wire

// File: rtl/csr_file.sv
`default_nettype none
// ============================================================================
// csr_file : RV64 machine-mode CSRs, trap entry / MRET, fetch redirect.
// Optional mcycle/minstret (+ cycle/instret shadows) under CSR_COUNTERS_EN.
// Rev 1.0
// ============================================================================
module csr_file #(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] HART_ID      = '0
) (
  input wire logic  CLK,
  input wire logic  RESET,
  csr_file_if.slave bus
);
  localparam logic [11:0] c_mstatus  = 12'h300;
  localparam logic [11:0] c_misa     = 12'h301;
  localparam logic [11:0] c_mie      = 12'h304;
  localparam logic [11:0] c_mtvec    = 12'h305;
  localparam logic [11:0] c_mscratch = 12'h340;
  localparam logic [11:0] c_mepc     = 12'h341;
  localparam logic [11:0] c_mcause   = 12'h342;
  localparam logic [11:0] c_mtval    = 12'h343;
  localparam logic [11:0] c_mip      = 12'h344;
  localparam logic [11:0] c_mhartid  = 12'hF14;
`ifdef CSR_COUNTERS_EN
  localparam logic [11:0] c_mcycle   = 12'hB00;
  localparam logic [11:0] c_minstret = 12'hB02;
  localparam logic [11:0] c_cycle    = 12'hC00;
  localparam logic [11:0] c_instret  = 12'hC02;
`endif

  logic            r_mie, r_mpie, r_mtie, r_meie, r_priv, r_redirect;
  logic [1:0]      r_mpp;
  logic [XLEN-1:0] r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval, r_redirect_pc;
`ifdef CSR_COUNTERS_EN
  logic [XLEN-1:0] r_mcycle, r_minstret;
`else
  logic            w_unused_retire;
  assign w_unused_retire = bus.WB_RETIRE;
`endif

  logic            w_wr_en;
  logic [11:0]     w_wa;
  logic [XLEN-1:0] w_wd, w_vec_base, w_trap_target, w_rd_data;
  logic            w_impl;

  // Trap and MRET both take precedence over, and discard, a same-cycle write.
  assign w_wr_en = bus.WB_ST_CSR & ~bus.WB_CS & ~bus.WB_MRET;
  assign w_wa    = bus.WB_CSR_ADDR;
  assign w_wd    = bus.WB_CSR_DATA;

  assign w_vec_base    = {r_mtvec[XLEN-1:2], 2'b00};
  assign w_trap_target = w_vec_base +
      ((r_mtvec[0] & bus.WB_CAUSE[XLEN-1]) ?
       {{(XLEN-8){1'b0}}, bus.WB_CAUSE[5:0], 2'b00} : '0);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_mie         <= 1'b0;
      r_mpie        <= 1'b0;
      r_mpp         <= 2'b11;
      r_mtie        <= 1'b0;
      r_meie        <= 1'b0;
      r_mtvec       <= RESET_VECTOR;
      r_mscratch    <= '0;
      r_mepc        <= '0;
      r_mcause      <= '0;
      r_mtval       <= '0;
      r_priv        <= 1'b1;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
`ifdef CSR_COUNTERS_EN
      r_mcycle      <= '0;
      r_minstret    <= '0;
`endif
    end else begin
      r_redirect <= 1'b0;
      if (bus.WB_CS) begin
        r_mepc        <= {bus.WB_TRAP_PC[XLEN-1:2], 2'b00};
        r_mcause      <= bus.WB_CAUSE;
        r_mtval       <= bus.WB_TVAL;
        r_mpie        <= r_mie;
        r_mie         <= 1'b0;
        r_mpp         <= {2{r_priv}};
        r_priv        <= 1'b1;
        r_redirect    <= 1'b1;
        r_redirect_pc <= w_trap_target;
      end else if (bus.WB_MRET) begin
        r_priv        <= (r_mpp == 2'b11);
        r_mie         <= r_mpie;
        r_mpie        <= 1'b1;
        r_mpp         <= 2'b00;
        r_redirect    <= 1'b1;
        r_redirect_pc <= r_mepc;
      end else if (w_wr_en) begin
        case (w_wa)
          c_mstatus: begin
            r_mie  <= w_wd[3];
            r_mpie <= w_wd[7];
            r_mpp  <= (w_wd[12:11] == 2'b11) ? 2'b11 : 2'b00;
          end
          c_mie: begin
            r_mtie <= w_wd[7];
            r_meie <= w_wd[11];
          end
          c_mtvec:    r_mtvec    <= {w_wd[XLEN-1:2], 1'b0, w_wd[0]};
          c_mscratch: r_mscratch <= w_wd;
          c_mepc:     r_mepc     <= {w_wd[XLEN-1:2], 2'b00};
          c_mcause:   r_mcause   <= w_wd;
          c_mtval:    r_mtval    <= w_wd;
          default:    ;
        endcase
      end
`ifdef CSR_COUNTERS_EN
      // A counter write replaces that cycle's increment rather than adding to it.
      if (w_wr_en && w_wa == c_mcycle) r_mcycle <= w_wd;
      else                             r_mcycle <= r_mcycle + 1'b1;
      if (w_wr_en && w_wa == c_minstret)      r_minstret <= w_wd;
      else if (bus.WB_RETIRE && !bus.WB_CS)   r_minstret <= r_minstret + 1'b1;
`endif
    end
  end

  always_comb begin
    w_rd_data = '0;
    w_impl    = 1'b1;
    case (bus.RD_ADDR)
      c_mstatus: begin
        w_rd_data[3]     = r_mie;
        w_rd_data[7]     = r_mpie;
        w_rd_data[12:11] = r_mpp;
      end
      c_misa: begin
        w_rd_data[XLEN-1:XLEN-2] = 2'b10;
        w_rd_data[8]             = 1'b1;
        w_rd_data[20]            = 1'b1;
      end
      c_mie: begin
        w_rd_data[7]  = r_mtie;
        w_rd_data[11] = r_meie;
      end
      c_mtvec:    w_rd_data = r_mtvec;
      c_mscratch: w_rd_data = r_mscratch;
      c_mepc:     w_rd_data = r_mepc;
      c_mcause:   w_rd_data = r_mcause;
      c_mtval:    w_rd_data = r_mtval;
      c_mip: begin
        w_rd_data[7]  = bus.TIMER;
        w_rd_data[11] = bus.EXTERNAL;
      end
      c_mhartid:  w_rd_data = HART_ID;
`ifdef CSR_COUNTERS_EN
      c_mcycle, c_cycle:     w_rd_data = r_mcycle;
      c_minstret, c_instret: w_rd_data = r_minstret;
`endif
      default:    w_impl = 1'b0;
    endcase
  end

  assign bus.RD_DATA     = w_rd_data;
  assign bus.RD_ILLEGAL  = ~w_impl | (~r_priv & (bus.RD_ADDR[9:8] == 2'b11));
  assign bus.REDIRECT    = r_redirect;
  assign bus.REDIRECT_PC = r_redirect_pc;
  assign bus.PRIVILEGE   = r_priv;
  assign bus.INT_REQ     = (~r_priv | r_mie) &
                           ((bus.TIMER & r_mtie) | (bus.EXTERNAL & r_meie));
endmodule
`default_nettype wire

// File: tb/tb_csr_file.sv
`default_nettype none
// ============================================================================
// tb_csr_file : directed scoreboard bench for csr_file (honours CSR_COUNTERS_EN)
// Rev 1.0
// ============================================================================
module tb_csr_file;
  localparam logic [63:0] c_rv   = 64'h0000_0000_0000_1000;
  localparam logic [63:0] c_hart = 64'd3;

  logic CLK;
  logic RESET;
  csr_file_if #(.XLEN(64)) bus ();

  csr_file #(.XLEN(64), .RESET_VECTOR(c_rv), .HART_ID(c_hart)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  logic [63:0] sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_val(input logic [63:0] v);
    sb.push_back(v);
  endtask

  task automatic check(input string tag, input logic [63:0] obs);
    logic [63:0] exp;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  task automatic chk_rd(input string tag, input logic [11:0] a, input logic [63:0] v);
    bus.RD_ADDR = a;
    expect_val(v);
    #1;
    check(tag, bus.RD_DATA);
  endtask

  task automatic chk_ill(input string tag, input logic [11:0] a, input logic v);
    bus.RD_ADDR = a;
    expect_val({63'd0, v});
    #1;
    check(tag, {63'd0, bus.RD_ILLEGAL});
  endtask

  task automatic wr(input logic [11:0] a, input logic [63:0] d);
    bus.WB_ST_CSR = 1'b1;
    bus.WB_CSR_ADDR = a;
    bus.WB_CSR_DATA = d;
    tick();
    bus.WB_ST_CSR = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b0;
    bus.RD_ADDR = 12'h0;     bus.WB_ST_CSR = 1'b0;  bus.WB_CSR_ADDR = 12'h0;
    bus.WB_CSR_DATA = '0;    bus.WB_RETIRE = 1'b0;  bus.WB_CS = 1'b0;
    bus.WB_CAUSE = '0;       bus.WB_TRAP_PC = '0;   bus.WB_TVAL = '0;
    bus.WB_MRET = 1'b0;      bus.TIMER = 1'b0;      bus.EXTERNAL = 1'b0;

    // Reset held while a trap and a write are requested: reset must win.
    bus.WB_CS = 1'b1; bus.WB_ST_CSR = 1'b1; bus.WB_CSR_ADDR = 12'h340; bus.WB_CSR_DATA = 64'hAA;
    tick(); tick();
    RESET = 1'b1; bus.WB_CS = 1'b0; bus.WB_ST_CSR = 1'b0;
    chk_rd("rst_mtvec", 12'h305, c_rv);
    chk_rd("rst_mstatus", 12'h300, 64'h1800);
    expect_val(64'd1); check("rst_priv", {63'd0, bus.PRIVILEGE});
    expect_val(64'd0); check("rst_redirect", {63'd0, bus.REDIRECT});
    expect_val(64'd0); check("rst_redirect_pc", bus.REDIRECT_PC);
    chk_rd("rst_mscratch", 12'h340, 64'h0);
    tick();
    chk_rd("misa", 12'h301, 64'h8000_0000_0010_0100);
    chk_rd("mhartid", 12'hF14, c_hart);
    chk_ill("ill_unimpl", 12'h7C0, 1'b1);
    chk_ill("legal_m_mstatus", 12'h300, 1'b0);

    // WARL masking on mtvec and mepc
    wr(12'h305, 64'h8000_0003);
    chk_rd("warl_mtvec", 12'h305, 64'h8000_0001);
    wr(12'h341, 64'h1003);
    chk_rd("warl_mepc", 12'h341, 64'h1000);

    // Enable MIE and MTIE, then timer interrupt level
    wr(12'h300, 64'h1808);
    wr(12'h304, 64'h80);
    chk_rd("mstatus_mie", 12'h300, 64'h1808);
    bus.TIMER = 1'b1;
    chk_rd("mip_timer", 12'h344, 64'h80);
    expect_val(64'd1); check("int_req_m", {63'd0, bus.INT_REQ});
    bus.TIMER = 1'b0;
    #1; expect_val(64'd0); check("int_req_off", {63'd0, bus.INT_REQ});
    tick();

    // Vectored interrupt trap
    bus.WB_CS = 1'b1; bus.WB_CAUSE = 64'h8000_0000_0000_0007;
    bus.WB_TRAP_PC = 64'h2000; bus.WB_TVAL = 64'h77;
    tick();
    bus.WB_CS = 1'b0;
    expect_val(64'd1); check("trap_redirect", {63'd0, bus.REDIRECT});
    expect_val(64'h8000_001C); check("trap_vec_pc", bus.REDIRECT_PC);
    chk_rd("trap_mepc", 12'h341, 64'h2000);
    chk_rd("trap_mstatus", 12'h300, 64'h1880);
    chk_rd("trap_mcause", 12'h342, 64'h8000_0000_0000_0007);
    chk_rd("trap_mtval", 12'h343, 64'h77);
    tick();
    expect_val(64'd0); check("trap_pulse_width", {63'd0, bus.REDIRECT});

    // MPP=01 stores 00; MRET to user mode
    wr(12'h300, 64'h0880);
    chk_rd("warl_mpp", 12'h300, 64'h0080);
    wr(12'h341, 64'h3000);
    bus.WB_MRET = 1'b1;
    tick();
    bus.WB_MRET = 1'b0;
    expect_val(64'd1); check("mret_redirect", {63'd0, bus.REDIRECT});
    expect_val(64'h3000); check("mret_pc", bus.REDIRECT_PC);
    expect_val(64'd0); check("mret_priv", {63'd0, bus.PRIVILEGE});
    chk_ill("ill_u_mstatus", 12'h300, 1'b1);
`ifdef CSR_COUNTERS_EN
    chk_ill("u_cycle_shadow", 12'hC00, 1'b0);
`else
    chk_ill("u_cycle_unimpl", 12'hC00, 1'b1);
`endif
    bus.TIMER = 1'b1;
    #1; expect_val(64'd1); check("int_req_u", {63'd0, bus.INT_REQ});
    bus.TIMER = 1'b0;
    tick();
    expect_val(64'd0); check("mret_pulse_width", {63'd0, bus.REDIRECT});

    // Trap + MRET + write in the same cycle: only the trap happens
    bus.WB_CS = 1'b1; bus.WB_MRET = 1'b1; bus.WB_ST_CSR = 1'b1;
    bus.WB_CSR_ADDR = 12'h340; bus.WB_CSR_DATA = 64'h55;
    bus.WB_CAUSE = 64'h2; bus.WB_TRAP_PC = 64'h4000; bus.WB_TVAL = 64'h0;
    tick();
    bus.WB_CS = 1'b0; bus.WB_MRET = 1'b0; bus.WB_ST_CSR = 1'b0;
    expect_val(64'h8000_0000); check("prio_pc", bus.REDIRECT_PC);
    expect_val(64'd1); check("prio_priv", {63'd0, bus.PRIVILEGE});
    chk_rd("prio_mscratch", 12'h340, 64'h0);
    chk_rd("prio_mstatus", 12'h300, 64'h0080);
    chk_rd("prio_mepc", 12'h341, 64'h4000);
    tick();

    // Back-to-back traps give back-to-back pulses
    bus.WB_CS = 1'b1; bus.WB_CAUSE = 64'h8000_0000_0000_000B; bus.WB_TRAP_PC = 64'h5000;
    tick();
    expect_val(64'd1); check("b2b_first", {63'd0, bus.REDIRECT});
    expect_val(64'h8000_002C); check("b2b_first_pc", bus.REDIRECT_PC);
    bus.WB_CAUSE = 64'h3;
    tick();
    bus.WB_CS = 1'b0;
    expect_val(64'd1); check("b2b_second", {63'd0, bus.REDIRECT});
    expect_val(64'h8000_0000); check("b2b_second_pc", bus.REDIRECT_PC);
    chk_rd("b2b_mstatus", 12'h300, 64'h1800);
    tick();
    expect_val(64'd0); check("b2b_end", {63'd0, bus.REDIRECT});

    // Reset overrides a simultaneous trap
    RESET = 1'b0; bus.WB_CS = 1'b1;
    tick();
    RESET = 1'b1; bus.WB_CS = 1'b0;
    expect_val(64'd0); check("rst2_redirect", {63'd0, bus.REDIRECT});
    chk_rd("rst2_mtvec", 12'h305, c_rv);
    chk_rd("rst2_mepc", 12'h341, 64'h0);

`ifdef CSR_COUNTERS_EN
    wr(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
    chk_rd("mcycle_written", 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    chk_rd("mcycle_wrap", 12'hB00, 64'h0);
    bus.WB_RETIRE = 1'b1;
    wr(12'hB02, 64'h10);
    chk_rd("minstret_write_wins", 12'hB02, 64'h10);
    tick();
    bus.WB_RETIRE = 1'b0;
    chk_rd("minstret_inc", 12'hC02, 64'h11);
`else
    chk_ill("no_mcycle", 12'hB00, 1'b1);
    wr(12'hB00, 64'h1234);
    chk_rd("no_mcycle_write", 12'hB00, 64'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
